// File: rtl/dllp_replay_scheduler.sv
// dllp_replay_scheduler
// Retry-slot sequencer for the data link layer. It hands out retry slots in
// circular order, retires them on cumulative ACKs (modulo-4096 compare), and
// walks outstanding slots in order when a NAK or replay-timer expiry occurs.
// REPLAY_NUM rollover parks the block in an error state until reset.
module dllp_replay_scheduler #(
    parameter int RETRY_TLP_SIZE = 4,
    parameter int REPLAY_TIMER   = 160,
    localparam int IDX_W         = $clog2(RETRY_TLP_SIZE)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tlp_store_vld_i,
    input  logic [11:0]      tlp_store_seq_i,
    output logic             alloc_avail_o,
    output logic [IDX_W-1:0] alloc_index_o,
    output logic [IDX_W:0]   outstanding_cnt_o,
    input  logic             ack_nack_vld_i,
    input  logic             ack_nack_i,
    input  logic [11:0]      ack_seq_num_i,
    output logic             replay_req_o,
    output logic [IDX_W-1:0] replay_index_o,
    input  logic             replay_ack_i,
    input  logic             replay_done_i,
    output logic             replay_active_o,
    output logic             replay_err_o
);

    localparam int TMR_W = $clog2(REPLAY_TIMER);

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_FREE        = 3'd1;
    localparam logic [2:0] ST_REPLAY_REQ  = 3'd2;
    localparam logic [2:0] ST_REPLAY_WAIT = 3'd3;
    localparam logic [2:0] ST_ERR         = 3'd4;

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W + 1)'(1);
    localparam logic [IDX_W:0]   CNT_FULL = (IDX_W + 1)'(RETRY_TLP_SIZE);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(REPLAY_TIMER - 1);

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [IDX_W:0]   r_count;
    logic [TMR_W-1:0] r_timer;
    logic [1:0]       r_rnum;
    logic [IDX_W-1:0] r_rp_ptr;
    logic [IDX_W-1:0] r_rp_end;
    logic [11:0]      r_pend_seq;
    logic             r_pend_vld;
    logic             r_pend_nak;
    logic [11:0]      r_seq [RETRY_TLP_SIZE];

    logic [2:0]       w_state_next;
    logic [IDX_W-1:0] w_head_next;
    logic [IDX_W:0]   w_count_next;
    logic [TMR_W-1:0] w_timer_next;
    logic [TMR_W-1:0] w_timer_inc;
    logic [1:0]       w_rnum_next;
    logic [IDX_W-1:0] w_rp_ptr_next;
    logic [IDX_W-1:0] w_rp_end_next;
    logic             w_store_acc;
    logic             w_free;
    logic             w_start;
    logic             w_clr_pend_vld;
    logic             w_clr_pend_nak;
    logic             w_count_nz;
    logic [11:0]      w_diff;
    logic             w_covered;

    // Output decode; everything is a register or a function of registers.
    assign replay_active_o   = (r_state == ST_REPLAY_REQ) || (r_state == ST_REPLAY_WAIT);
    assign replay_err_o      = (r_state == ST_ERR);
    assign replay_req_o      = (r_state == ST_REPLAY_REQ);
    assign replay_index_o    = r_rp_ptr;
    assign alloc_index_o     = r_tail;
    assign outstanding_cnt_o = r_count;
    assign alloc_avail_o     = (r_count != CNT_FULL) && !replay_active_o && !replay_err_o;

    assign w_store_acc = tlp_store_vld_i && alloc_avail_o;
    assign w_count_nz  = (r_count != '0);

    // Head slot is covered when the pending ACK is at most 2047 ahead of it.
    assign w_diff    = r_pend_seq - r_seq[r_head];
    assign w_covered = (w_diff < 12'd2048);

    // Timer only runs with something outstanding; saturate so expiry cannot be skipped.
    assign w_timer_inc = !w_count_nz ? '0 :
                         (r_timer == TMR_MAX) ? TMR_MAX : r_timer + TMR_W'(1);

    // Per-slot sequence-number storage; contents are meaningless until written.
    generate
        for (genvar gi = 0; gi < RETRY_TLP_SIZE; gi++) begin : g_seq
            // Capture the sequence number when the TX path stores into this slot.
            always_ff @(posedge clk_i) begin
                if (w_store_acc && (r_tail == IDX_W'(gi))) begin
                    r_seq[gi] <= tlp_store_seq_i;
                end
            end
        end
    endgenerate

    // Next-state logic for the retire/replay sequencer.
    always_comb begin
        w_state_next   = r_state;
        w_head_next    = r_head;
        w_timer_next   = r_timer;
        w_rnum_next    = r_rnum;
        w_rp_ptr_next  = r_rp_ptr;
        w_rp_end_next  = r_rp_end;
        w_free         = 1'b0;
        w_start        = 1'b0;
        w_clr_pend_vld = 1'b0;
        w_clr_pend_nak = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_timer_next = w_timer_inc;
                if (r_pend_vld) begin
                    w_state_next   = ST_FREE;
                    w_clr_pend_vld = 1'b1;
                end else if (w_count_nz && (r_timer == TMR_MAX)) begin
                    w_start = 1'b1;
                end
            end
            ST_FREE: begin
                w_timer_next = w_timer_inc;
                if (w_count_nz && w_covered) begin
                    w_free       = 1'b1;
                    w_head_next  = r_head + IDX_ONE;
                    w_timer_next = '0;
                    w_rnum_next  = '0;
                end else if (r_pend_nak) begin
                    w_clr_pend_nak = 1'b1;
                    if (w_count_nz) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REPLAY_REQ: begin
                if (replay_ack_i) begin
                    w_state_next = ST_REPLAY_WAIT;
                end
            end
            ST_REPLAY_WAIT: begin
                if (replay_done_i) begin
                    w_rp_ptr_next = r_rp_ptr + IDX_ONE;
                    if (w_rp_ptr_next == r_rp_end) begin
                        w_timer_next = '0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_REPLAY_REQ;
                    end
                end
            end
            ST_ERR: begin
                w_state_next = ST_ERR;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // Replay start is shared by NAK and timer expiry; rollover is fatal.
        if (w_start) begin
            if (r_rnum == 2'd3) begin
                w_state_next = ST_ERR;
            end else begin
                w_rnum_next   = r_rnum + 2'd1;
                w_rp_ptr_next = r_head;
                w_rp_end_next = r_tail;
                w_state_next  = ST_REPLAY_REQ;
            end
        end
    end

    // Occupancy nets a store and a free landing in the same cycle.
    always_comb begin
        w_count_next = r_count;
        if (w_store_acc && !w_free) begin
            w_count_next = r_count + CNT_ONE;
        end else if (!w_store_acc && w_free) begin
            w_count_next = r_count - CNT_ONE;
        end
    end

    // Sequencer and queue-pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_timer  <= '0;
            r_rnum   <= '0;
            r_rp_ptr <= '0;
            r_rp_end <= '0;
        end else begin
            r_state  <= w_state_next;
            r_head   <= w_head_next;
            r_tail   <= w_store_acc ? r_tail + IDX_ONE : r_tail;
            r_count  <= w_count_next;
            r_timer  <= w_timer_next;
            r_rnum   <= w_rnum_next;
            r_rp_ptr <= w_rp_ptr_next;
            r_rp_end <= w_rp_end_next;
        end
    end

    // Latch ACK/NAK events in any state; a new event beats a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend_seq <= '0;
            r_pend_vld <= 1'b0;
            r_pend_nak <= 1'b0;
        end else begin
            if (ack_nack_vld_i) begin
                r_pend_seq <= ack_seq_num_i;
                r_pend_vld <= 1'b1;
            end else if (w_clr_pend_vld) begin
                r_pend_vld <= 1'b0;
            end
            if (ack_nack_vld_i && !ack_nack_i) begin
                r_pend_nak <= 1'b1;
            end else if (w_clr_pend_nak) begin
                r_pend_nak <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dllp_replay_scheduler.sv
// Directed bench for dllp_replay_scheduler: allocation, cumulative ACK with
// wrap, NAK replay handshake, timer replays up to rollover, ACK latched during
// replay, and asynchronous reset mid-replay.
module tb_dllp_replay_scheduler;

    localparam int RT = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_vld = 1'b0;
    logic [11:0] st_seq = '0;
    logic        avail;
    logic [1:0]  aidx;
    logic [2:0]  cnt;
    logic        an_vld = 1'b0;
    logic        an = 1'b0;
    logic [11:0] an_seq = '0;
    logic        req;
    logic [1:0]  ridx;
    logic        rack = 1'b0;
    logic        rdone = 1'b0;
    logic        active;
    logic        err;

    int checks = 0;
    int errors = 0;
    int n;

    dllp_replay_scheduler #(.RETRY_TLP_SIZE(4), .REPLAY_TIMER(RT)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .tlp_store_vld_i(st_vld), .tlp_store_seq_i(st_seq),
        .alloc_avail_o(avail), .alloc_index_o(aidx), .outstanding_cnt_o(cnt),
        .ack_nack_vld_i(an_vld), .ack_nack_i(an), .ack_seq_num_i(an_seq),
        .replay_req_o(req), .replay_index_o(ridx),
        .replay_ack_i(rack), .replay_done_i(rdone),
        .replay_active_o(active), .replay_err_o(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_av, input logic [1:0] e_ai,
                            input logic [2:0] e_cnt, input logic e_req, input logic [1:0] e_ri,
                            input logic e_act, input logic e_err);
        chk({tag, "_avail"}, 32'(avail), 32'(e_av));
        chk({tag, "_aidx"},  32'(aidx),  32'(e_ai));
        chk({tag, "_cnt"},   32'(cnt),   32'(e_cnt));
        chk({tag, "_req"},   32'(req),   32'(e_req));
        chk({tag, "_ridx"},  32'(ridx),  32'(e_ri));
        chk({tag, "_act"},   32'(active), 32'(e_act));
        chk({tag, "_err"},   32'(err),   32'(e_err));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [11:0] s);
        st_vld = 1'b1;
        st_seq = s;
        step();
        st_vld = 1'b0;
    endtask

    task automatic dllp(input logic is_ack, input logic [11:0] s);
        an_vld = 1'b1;
        an     = is_ack;
        an_seq = s;
        step();
        an_vld = 1'b0;
    endtask

    task automatic serve(input string tag, input logic [1:0] e_idx);
        chk({tag, "_req"},  32'(req),  32'd1);
        chk({tag, "_ridx"}, 32'(ridx), 32'(e_idx));
        rack = 1'b1;
        step();
        rack = 1'b0;
        chk({tag, "_req_drop"}, 32'(req), 32'd0);
        rdone = 1'b1;
        step();
        rdone = 1'b0;
    endtask

    task automatic wait_req(input int bound, output int cyc);
        cyc = 0;
        while (req !== 1'b1 && cyc < bound) begin
            step();
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        // Reset values
        step();
        chk_outs("rst", 1'b1, 2'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        // Fill all four slots, store while full is ignored, ACK 1 frees two
        store(12'd0); store(12'd1); store(12'd2); store(12'd3);
        chk("s1_cnt_full", 32'(cnt), 32'd4);
        chk("s1_avail_full", 32'(avail), 32'd0);
        chk("s1_aidx_wrap", 32'(aidx), 32'd0);
        store(12'd9);
        chk("s1_store_ignored", 32'(cnt), 32'd4);
        dllp(1'b1, 12'd1);
        step(); step();
        chk("s1_first_free", 32'(cnt), 32'd3);
        step();
        chk("s1_second_free", 32'(cnt), 32'd2);
        step();
        chk("s1_cnt_final", 32'(cnt), 32'd2);
        chk("s1_avail", 32'(avail), 32'd1);
        // NAK 1 frees nothing; replay starts at head slot 2
        dllp(1'b0, 12'd1);
        step(); step();
        chk("s1_nak_req", 32'(req), 32'd1);
        chk("s1_nak_head", 32'(ridx), 32'd2);
        chk("s1_nak_active", 32'(active), 32'd1);
        chk("s1_nak_noalloc", 32'(avail), 32'd0);

        // Modulo-4096 wrap and stale/duplicate ACKs
        do_reset();
        store(12'd4094); store(12'd4095); store(12'd0);
        chk("s2_cnt3", 32'(cnt), 32'd3);
        dllp(1'b1, 12'd0);
        step(); step();
        chk("s2_free_a", 32'(cnt), 32'd2);
        step();
        chk("s2_free_b", 32'(cnt), 32'd1);
        step();
        chk("s2_free_c", 32'(cnt), 32'd0);
        step();
        chk("s2_aidx", 32'(aidx), 32'd3);
        store(12'd1);
        chk("s2_tail_wrap", 32'(aidx), 32'd0);
        dllp(1'b1, 12'd4093);
        repeat (4) step();
        chk("s2_stale_ack", 32'(cnt), 32'd1);
        dllp(1'b1, 12'd0);
        repeat (4) step();
        chk("s2_dup_ack", 32'(cnt), 32'd1);
        chk("s2_dup_noreq", 32'(req), 32'd0);
        dllp(1'b1, 12'd1);
        step(); step();
        chk("s2_ack1_frees", 32'(cnt), 32'd0);

        // NAK 5 with 5,6,7 outstanding: free slot 0, replay slots 1 and 2
        do_reset();
        store(12'd5); store(12'd6); store(12'd7);
        dllp(1'b0, 12'd5);
        step(); step();
        chk("s3_cnt_after_free", 32'(cnt), 32'd2);
        chk("s3_no_req_yet", 32'(req), 32'd0);
        step();
        chk("s3_req1", 32'(req), 32'd1);
        chk("s3_idx1", 32'(ridx), 32'd1);
        chk("s3_active", 32'(active), 32'd1);
        chk("s3_noalloc", 32'(avail), 32'd0);
        rack = 1'b1;
        step();
        rack = 1'b0;
        chk("s3_req_drop", 32'(req), 32'd0);
        step();
        chk("s3_wait_hold", 32'(req), 32'd0);
        rdone = 1'b1;
        step();
        rdone = 1'b0;
        chk("s3_req2", 32'(req), 32'd1);
        chk("s3_idx2", 32'(ridx), 32'd2);
        rack = 1'b1;
        rdone = 1'b1;
        step();
        rack = 1'b0;
        rdone = 1'b0;
        chk("s3_ackdone_req", 32'(req), 32'd0);
        step();
        chk("s3_done_ignored", 32'(active), 32'd1);
        rdone = 1'b1;
        step();
        rdone = 1'b0;
        chk("s3_end_active", 32'(active), 32'd0);
        chk("s3_end_cnt", 32'(cnt), 32'd2);
        chk("s3_end_avail", 32'(avail), 32'd1);

        // Timer replays: three succeed, the fourth expiry is a rollover
        do_reset();
        store(12'd9);
        wait_req(RT + 4, n);
        chk("s4_expiry1_cycles", 32'(n), 32'(RT));
        serve("s4_rp1", 2'd0);
        wait_req(RT + 4, n);
        chk("s4_expiry2_cycles", 32'(n), 32'(RT));
        serve("s4_rp2", 2'd0);
        wait_req(RT + 4, n);
        chk("s4_expiry3_cycles", 32'(n), 32'(RT));
        serve("s4_rp3", 2'd0);
        wait_req(RT + 4, n);
        chk("s4_no_4th_req", 32'(n), 32'(RT + 4));
        chk("s4_err", 32'(err), 32'd1);
        chk("s4_err_noalloc", 32'(avail), 32'd0);
        chk("s4_err_inactive", 32'(active), 32'd0);

        // A freeing ACK between replays restarts the REPLAY_NUM count
        do_reset();
        store(12'd10); store(12'd11);
        for (int k = 0; k < 2; k++) begin
            wait_req(RT + 4, n);
            serve("s5_pre_a", 2'd0);
            serve("s5_pre_b", 2'd1);
        end
        dllp(1'b1, 12'd10);
        repeat (3) step();
        chk("s5_freed", 32'(cnt), 32'd1);
        for (int k = 0; k < 3; k++) begin
            wait_req(RT + 4, n);
            serve("s5_post", 2'd1);
            chk("s5_post_noerr", 32'(err), 32'd0);
        end
        wait_req(RT + 4, n);
        chk("s5_rollover_err", 32'(err), 32'd1);

        // ACK 3 arriving mid-replay is held until the replay completes
        do_reset();
        store(12'd2); store(12'd3); store(12'd4);
        dllp(1'b0, 12'd1);
        step(); step();
        chk("s6_req", 32'(req), 32'd1);
        chk("s6_idx0", 32'(ridx), 32'd0);
        an_vld = 1'b1;
        an     = 1'b1;
        an_seq = 12'd3;
        rack   = 1'b1;
        step();
        an_vld = 1'b0;
        rack   = 1'b0;
        chk("s6_req_drop", 32'(req), 32'd0);
        rdone = 1'b1;
        step();
        rdone = 1'b0;
        serve("s6_rp1", 2'd1);
        chk("s6_cnt_held", 32'(cnt), 32'd3);
        serve("s6_rp2", 2'd2);
        repeat (4) step();
        chk("s6_cnt_after", 32'(cnt), 32'd1);
        chk("s6_idle", 32'(active), 32'd0);
        chk("s6_aidx", 32'(aidx), 32'd3);

        // Asynchronous reset while a request is up
        dllp(1'b0, 12'd3);
        step(); step();
        chk("s7_req_up", 32'(req), 32'd1);
        chk("s7_req_idx", 32'(ridx), 32'd2);
        rst_n = 1'b0;
        #1;
        chk_outs("s7_async", 1'b1, 2'd0, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        store(12'd50);
        chk("s7_slot0_used", 32'(aidx), 32'd1);
        chk("s7_cnt", 32'(cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dllp_replay_scheduler.md
# dllp_replay_scheduler

Sequencing controller for the data link layer retry buffer. It allocates retry slots to outgoing TLPs in circular order and records each TLP's 12-bit sequence number. It retires slots on cumulative ACK DLLPs using modulo-4096 comparison, and schedules ordered replays of outstanding slots on NAK or replay-timer expiry. It sits between the DLLP receive decoder, the TLP transmit path and the retry buffer read/replay engine, and owns REPLAY_NUM and replay-timer policy.

## Interface
Parameters:
- RETRY_TLP_SIZE, 4, number of retry slots (power of two, ≥2); IDX_W = $clog2(RETRY_TLP_SIZE)
- REPLAY_TIMER, 160, replay-timer expiry in clock cycles (≥4)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- tlp_store_vld_i  in  1  TX path stored one TLP into slot alloc_index_o this cycle
- tlp_store_seq_i  in  12  sequence number of that TLP
- alloc_avail_o  out  1  a slot is free and stores are permitted
- alloc_index_o  out  IDX_W  slot the next store must use (tail pointer)
- outstanding_cnt_o  out  IDX_W+1  number of unacknowledged slots
- ack_nack_vld_i  in  1  DLLP ACK/NAK received
- ack_nack_i  in  1  1 = ACK, 0 = NAK
- ack_seq_num_i  in  12  AckNak_Seq_Num
- replay_req_o  out  1  request the replay engine to resend slot replay_index_o
- replay_index_o  out  IDX_W  slot to replay
- replay_ack_i  in  1  engine accepted the request
- replay_done_i  in  1  engine finished the slot (tlast accepted)
- replay_active_o  out  1  a replay sequence is in progress
- replay_err_o  out  1  sticky REPLAY_NUM rollover; link retrain required

## Operation
- Circular queue: head = oldest outstanding slot, tail = alloc_index_o, count = outstanding_cnt_o. Per-slot 12-bit seq register, not reset.
- alloc_avail_o = (count != RETRY_TLP_SIZE) && !replay_active_o && !replay_err_o. A store is accepted only when alloc_avail_o=1; otherwise tlp_store_vld_i is ignored. An accepted store writes seq[tail], increments tail (wraps at RETRY_TLP_SIZE-1→0) and increments count.
- Acked test: slot seq s is covered by A when (A − s) mod 4096 < 2048, using 12-bit unsigned subtraction with bit 11 = 0.
- Pending register: every ack_nack_vld_i overwrites pend_seq with ack_seq_num_i and sets pend_vld. A NAK additionally sets sticky pend_nak. Events arriving in any state are latched and never dropped; later ACKs subsume earlier ones.
- FSM:
  - ST_IDLE: priority is pend_vld → ST_FREE (clear pend_vld); else timer expiry with count≠0 → replay start; else hold.
  - ST_FREE: one slot per cycle. If count≠0 and seq[head] is covered, free head: head++, count−−, timer←0, replay_num←0. Otherwise, if pend_nak and count≠0 → replay start (clear pend_nak); if pend_nak and count=0 → clear pend_nak, go to ST_IDLE; else ST_IDLE. A store in the same cycle as a free is allowed; count nets the two.
  - Replay start: if replay_num==3 → ST_ERR. Else replay_num++, rp_ptr←head, rp_end←tail, → ST_REPLAY_REQ.
  - ST_REPLAY_REQ: replay_req_o=1, replay_index_o=rp_ptr. Held stable until replay_ack_i, then → ST_REPLAY_WAIT.
  - ST_REPLAY_WAIT: on replay_done_i, rp_ptr++. If rp_ptr+1==rp_end → timer←0, ST_IDLE; else → ST_REPLAY_REQ.
  - ST_ERR: replay_err_o=1, no requests, no allocation. Exit only by reset.
- replay_active_o = 1 in ST_REPLAY_REQ and ST_REPLAY_WAIT.
- Replay timer: increments in ST_IDLE and ST_FREE while count≠0. Held at 0 when count=0; frozen during replay. Expiry occurs when the timer equals REPLAY_TIMER−1. An ACK pending in the expiry cycle takes precedence.
- A duplicate or stale ACK (frees nothing) changes nothing, including replay_num.

## Timing
- Reset values: alloc_avail_o=1, alloc_index_o=0, outstanding_cnt_o=0, replay_req_o=0, replay_index_o=0, replay_active_o=0, replay_err_o=0. Also FSM=ST_IDLE, timer=0, replay_num=0, pend_vld=pend_nak=0.
- All outputs are registered or decoded from registers. A store in cycle N is visible on alloc_index_o and outstanding_cnt_o in N+1.
- ACK in cycle N → ST_IDLE in N+1 → ST_FREE in N+2 → first free visible at N+3. Each additional covered slot adds one cycle.
- NAK replay: replay_req_o asserts the cycle after the last free decision and deasserts the cycle after replay_ack_i. The next request comes no earlier than the cycle after replay_done_i.
- replay_ack_i and replay_done_i in the same cycle: the ack is taken; the done is honoured in ST_REPLAY_WAIT only.
- Reset mid-replay: all state returns to reset values immediately. replay_req_o drops asynchronously.

## Test plan
- Store seq 0,1,2,3 → alloc_avail_o=0 after the 4th, count=4. Then ACK 1 → two frees on consecutive cycles, count=2, head=2, alloc_avail_o=1.
- Wrap: store 4094, 4095, 0, then ACK 0 → all three freed, count=0. Then ACK 4093 → no change.
- Outstanding 5,6,7; NAK 5 → slot(5) freed. Then req index(6), ack, done, req index(7), ack, done → ST_IDLE, count=2, replay_num=1.
- Store one TLP, no ACK → replay_req_o rises REPLAY_TIMER+1 cycles after store. Three timeout replays, then the 4th expiry → replay_err_o=1, no 4th request. An ACK freeing a slot between replays resets replay_num to 0.
- ACK 3 arriving during replay of 2,3,4 → latched. After replay completes, slots 2,3 are freed and count=1.
- rst_ni low while replay_req_o=1 → all outputs at reset values. A store after release uses slot 0.
